riscv_parcel_queue: RTL and testbench

- Parametrised instruction-parcel buffer between the fetch bus and the decoder; replaces the fixed single-parcel hand-off in instruction fetch.
- Stores incoming parcels as 16-bit halfwords with per-halfword PC and fault flags.
- Reassembles halfwords into 16-bit (RVC) or 32-bit instructions and handles misaligned jump targets.
- Supports pipeline flush and independent producer/consumer stalls.

---
 rtl/riscv_pkg.sv | 23 ++
 rtl/riscv_parcel_hw_ram.sv | 33 +++
 rtl/riscv_parcel_queue.sv | 143 ++++++++++++++
 tb/tb_riscv_parcel_queue.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared types and constants for the instruction-parcel queue.
package riscv_pkg;

   // Width of the PC stored alongside each halfword.
   localparam int PC_W = 32;

   // Low two bits of a 32-bit (non-compressed) instruction.
   localparam logic [1:0] RVC_MASK = 2'b11;

   // One stored halfword with its own PC and fetch fault flags.
   typedef struct packed {
      logic [15:0]     hw;
      logic [PC_W-1:0] pc;
      logic            misaligned;
      logic            page_fault;
   } parcel_hw_t;

   // True when either fetch fault flag is attached to the halfword.
   function automatic logic hw_faulted(input parcel_hw_t h);
      return h.misaligned | h.page_fault;
   endfunction

endpackage

// File: rtl/riscv_parcel_hw_ram.sv
// Halfword store: two write ports for a full parcel, two combinational read
// ports so the head and the next halfword are visible together.
module riscv_parcel_hw_ram
   import riscv_pkg::*;
#(
   parameter int DEPTH = 8,
   localparam int PW = $clog2(DEPTH)
) (
   input  logic            clk,
   input  logic            we0,
   input  logic [PW-1:0]   wa0,
   input  parcel_hw_t      wd0,
   input  logic            we1,
   input  logic [PW-1:0]   wa1,
   input  parcel_hw_t      wd1,
   input  logic [PW-1:0]   ra0,
   input  logic [PW-1:0]   ra1,
   output parcel_hw_t      rd0,
   output parcel_hw_t      rd1
);

   parcel_hw_t mem [DEPTH];

   // Write both halves of a parcel; addresses never collide because wa1 = wa0 + 1.
   always_ff @(posedge clk) begin
      if (we0) mem[wa0] <= wd0;
      if (we1) mem[wa1] <= wd1;
   end

   assign rd0 = mem[ra0];
   assign rd1 = mem[ra1];

endmodule

// File: rtl/riscv_parcel_queue.sv
// Instruction-parcel queue: buffers fetch parcels as halfwords and hands
// complete 16/32-bit instructions to the decoder.
module riscv_parcel_queue
   import riscv_pkg::*;
#(
   parameter int XLEN        = PC_W,
   parameter int PARCEL_SIZE = 32,
   parameter int INSTR_SIZE  = 32,
   parameter int DEPTH       = 8,
   parameter bit HAS_RVC     = 1'b0,
   localparam int PW = $clog2(DEPTH),
   localparam int CW = $clog2(DEPTH) + 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   input  logic                   parcel_valid,
   input  logic [PARCEL_SIZE-1:0] parcel,
   input  logic [XLEN-1:0]        parcel_pc,
   input  logic                   parcel_misaligned,
   input  logic                   parcel_page_fault,
   output logic                   parcel_ready,
   output logic                   instr_valid,
   input  logic                   instr_ready,
   output logic [INSTR_SIZE-1:0]  instr,
   output logic [XLEN-1:0]        instr_pc,
   output logic                   instr_is_rvc,
   output logic                   instr_misaligned,
   output logic                   instr_page_fault,
   output logic [CW-1:0]          count
);

   logic [PW-1:0] wp_reg, rp_reg;
   logic [CW-1:0] count_reg;

   parcel_hw_t    wd0, wd1, h0, h1;
   logic          two_hw;
   logic          wr_en, rd_en;
   logic [1:0]    n_wr, n_rd;
   logic [CW-1:0] free_hw;

   // Space check uses registered count only, so a same-cycle pop never frees room.
   assign free_hw      = CW'(DEPTH) - count_reg;
   assign parcel_ready = (free_hw >= CW'(PARCEL_SIZE / 16));
   assign wr_en        = parcel_valid && parcel_ready && !flush;

   generate
      if (PARCEL_SIZE == 32) begin : g_p32
         // Aligned parcel splits into two halfwords; odd target keeps only the upper one.
         always_comb begin
            two_hw         = !parcel_pc[1];
            wd0.hw         = two_hw ? parcel[15:0] : parcel[31:16];
            wd0.pc         = PC_W'(parcel_pc);
            wd0.misaligned = parcel_misaligned;
            wd0.page_fault = parcel_page_fault;
            wd1.hw         = parcel[31:16];
            wd1.pc         = PC_W'(parcel_pc) + PC_W'(2);
            wd1.misaligned = parcel_misaligned;
            wd1.page_fault = parcel_page_fault;
         end
      end else begin : g_p16
         // Narrow bus delivers exactly one halfword per parcel.
         always_comb begin
            two_hw         = 1'b0;
            wd0.hw         = parcel[15:0];
            wd0.pc         = PC_W'(parcel_pc);
            wd0.misaligned = parcel_misaligned;
            wd0.page_fault = parcel_page_fault;
            wd1            = wd0;
         end
      end
   endgenerate

   assign n_wr = wr_en ? (two_hw ? 2'd2 : 2'd1) : 2'd0;

   riscv_parcel_hw_ram #(.DEPTH(DEPTH)) u_ram (
      .clk (clk),
      .we0 (wr_en),
      .wa0 (wp_reg),
      .wd0 (wd0),
      .we1 (wr_en && two_hw),
      .wa1 (wp_reg + PW'(1)),
      .wd1 (wd1),
      .ra0 (rp_reg),
      .ra1 (rp_reg + PW'(1)),
      .rd0 (h0),
      .rd1 (h1)
   );

   logic h0_fault, h0_short, head_avail;
   logic unused_h1_pc;

   assign unused_h1_pc = ^h1.pc;

   // Head decode: a faulted or compressed head goes out alone, otherwise pair it with h1.
   always_comb begin
      h0_fault   = hw_faulted(h0);
      h0_short   = h0_fault || (HAS_RVC && (h0.hw[1:0] != RVC_MASK));
      head_avail = h0_short ? (count_reg >= CW'(1)) : (count_reg >= CW'(2));

      instr_valid      = head_avail && !flush;
      instr            = '0;
      instr_pc         = '0;
      instr_is_rvc     = 1'b0;
      instr_misaligned = 1'b0;
      instr_page_fault = 1'b0;
      if (instr_valid) begin
         instr_pc = XLEN'(h0.pc);
         if (h0_short) begin
            instr            = INSTR_SIZE'(h0.hw);
            instr_is_rvc     = !h0_fault;
            instr_misaligned = h0.misaligned;
            instr_page_fault = h0.page_fault;
         end else begin
            instr            = INSTR_SIZE'({h1.hw, h0.hw});
            instr_misaligned = h0.misaligned | h1.misaligned;
            instr_page_fault = h0.page_fault | h1.page_fault;
         end
      end
   end

   assign rd_en = instr_valid && instr_ready;
   assign n_rd  = rd_en ? (h0_short ? 2'd1 : 2'd2) : 2'd0;
   assign count = count_reg;

   // Pointer and occupancy update; flush wins over the same-cycle write and read.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wp_reg    <= '0;
         rp_reg    <= '0;
         count_reg <= '0;
      end else if (flush) begin
         wp_reg    <= '0;
         rp_reg    <= '0;
         count_reg <= '0;
      end else begin
         wp_reg    <= wp_reg + PW'(n_wr);
         rp_reg    <= rp_reg + PW'(n_rd);
         count_reg <= count_reg + CW'(n_wr) - CW'(n_rd);
      end
   end

endmodule

// File: tb/tb_riscv_parcel_queue.sv
// Directed bench for riscv_parcel_queue (RVC on, 32-bit parcels, depth 8).
module tb_riscv_parcel_queue;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic        parcel_valid = 1'b0;
   logic [31:0] parcel = '0;
   logic [31:0] parcel_pc = '0;
   logic        parcel_misaligned = 1'b0;
   logic        parcel_page_fault = 1'b0;
   logic        parcel_ready;
   logic        instr_valid;
   logic        instr_ready = 1'b0;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_is_rvc;
   logic        instr_misaligned;
   logic        instr_page_fault;
   logic [3:0]  count;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   riscv_parcel_queue #(
      .XLEN(32), .PARCEL_SIZE(32), .INSTR_SIZE(32), .DEPTH(8), .HAS_RVC(1'b1)
   ) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .parcel_valid(parcel_valid), .parcel(parcel), .parcel_pc(parcel_pc),
      .parcel_misaligned(parcel_misaligned), .parcel_page_fault(parcel_page_fault),
      .parcel_ready(parcel_ready),
      .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
      .instr_pc(instr_pc), .instr_is_rvc(instr_is_rvc),
      .instr_misaligned(instr_misaligned), .instr_page_fault(instr_page_fault),
      .count(count)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   // Offer one parcel for one clock; the queue is expected to have room.
   task automatic push(input logic [31:0] data, input logic [31:0] pc, input logic pf);
      parcel_valid      = 1'b1;
      parcel            = data;
      parcel_pc         = pc;
      parcel_page_fault = pf;
      #1;
      check("push_ready", parcel_ready, 1'b1);
      $display("push data=%08h pc=%08h pf=%0b", data, pc, pf);
      @(posedge clk);
      #1;
      parcel_valid      = 1'b0;
      parcel_page_fault = 1'b0;
   endtask

   // Take the head instruction and compare it against the expected one.
   task automatic pop(input string tag, input logic [31:0] exp_instr,
                      input logic [31:0] exp_pc, input logic exp_rvc);
      instr_ready = 1'b1;
      #1;
      check({tag, "_valid"}, instr_valid, 1'b1);
      check({tag, "_instr"}, instr, exp_instr);
      check({tag, "_pc"}, instr_pc, exp_pc);
      check({tag, "_rvc"}, instr_is_rvc, exp_rvc);
      $display("pop  %s instr=%08h pc=%08h rvc=%0b", tag, instr, instr_pc, instr_is_rvc);
      @(posedge clk);
      #1;
      instr_ready = 1'b0;
   endtask

   initial begin
      // Reset values
      #2;
      check("rst_count", count, 4'd0);
      check("rst_valid", instr_valid, 1'b0);
      check("rst_ready", parcel_ready, 1'b1);
      check("rst_instr", instr, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Mixed 32-bit and compressed stream
      push(32'h00A0_0513, 32'h200, 1'b0);
      #1;
      check("seq_count2", count, 4'd2);
      push(32'h4501_4505, 32'h204, 1'b0);
      #1;
      check("seq_count4", count, 4'd4);
      pop("seq0", 32'h00A00513, 32'h200, 1'b0);
      pop("seq1", 32'h00004505, 32'h204, 1'b1);
      pop("seq2", 32'h00004501, 32'h206, 1'b1);
      check("seq_empty", count, 4'd0);

      // Odd-halfword jump target
      push(32'h1234_4505, 32'h302, 1'b0);
      #1;
      check("odd_count", count, 4'd1);
      pop("odd", 32'h00001234, 32'h302, 1'b1);

      // 32-bit instruction split across two parcels
      push(32'h0513_4505, 32'h400, 1'b0);
      pop("split0", 32'h00004505, 32'h400, 1'b1);
      check("split_wait", instr_valid, 1'b0);
      push(32'h0000_00A0, 32'h404, 1'b0);
      pop("split1", 32'h00A00513, 32'h402, 1'b0);
      pop("split2", 32'h00000000, 32'h406, 1'b1);
      check("split_empty", count, 4'd0);

      // Fill to capacity with no consumer
      for (int i = 0; i < 4; i++) push(32'h0000_0513 | (32'(i) << 20), 32'h500 + 32'(4 * i), 1'b0);
      #1;
      check("fill_count", count, 4'd8);
      check("fill_ready", parcel_ready, 1'b0);
      parcel_valid = 1'b1;
      parcel       = 32'h0050_0513;
      parcel_pc    = 32'h510;
      @(posedge clk);
      #1;
      check("fill_held", count, 4'd8);
      instr_ready = 1'b1;
      @(posedge clk);
      #1;
      instr_ready = 1'b0;
      check("fill_popped", count, 4'd6);
      check("fill_ready_again", parcel_ready, 1'b1);
      @(posedge clk);
      #1;
      parcel_valid = 1'b0;
      check("fill_fifth_in", count, 4'd8);
      for (int i = 1; i < 4; i++) pop("fill", 32'h0000_0513 | (32'(i) << 20), 32'h500 + 32'(4 * i), 1'b0);
      pop("fill5", 32'h00500513, 32'h510, 1'b0);
      check("fill_empty", count, 4'd0);

      // Page fault on the second halfword of a 32-bit instruction
      push(32'h0513_0000, 32'h602, 1'b0);
      push(32'h0000_00A0, 32'h604, 1'b1);
      #1;
      check("pf_valid", instr_valid, 1'b1);
      check("pf_flag", instr_page_fault, 1'b1);
      check("pf_mis", instr_misaligned, 1'b0);
      pop("pf32", 32'h00A00513, 32'h602, 1'b0);
      check("pf_head_flag", instr_page_fault, 1'b1);
      pop("pf16", 32'h00000000, 32'h606, 1'b0);

      // Flush with a concurrent write and pop at count 5
      push(32'h00A0_0513, 32'h700, 1'b0);
      push(32'h00A0_0513, 32'h704, 1'b0);
      push(32'h0513_0000, 32'h70A, 1'b0);
      #1;
      check("fl_count5", count, 4'd5);
      flush        = 1'b1;
      parcel_valid = 1'b1;
      parcel       = 32'h1111_4505;
      parcel_pc    = 32'h800;
      instr_ready  = 1'b1;
      #1;
      check("fl_valid_forced", instr_valid, 1'b0);
      @(posedge clk);
      #1;
      flush        = 1'b0;
      parcel_valid = 1'b0;
      instr_ready  = 1'b0;
      #1;
      check("fl_count0", count, 4'd0);
      check("fl_valid0", instr_valid, 1'b0);
      check("fl_instr0", instr, 32'h0);
      @(posedge clk);
      #1;
      check("fl_still0", count, 4'd0);
      push(32'h2222_4505, 32'h900, 1'b0);
      pop("fl_after0", 32'h00004505, 32'h900, 1'b1);
      pop("fl_after1", 32'h00002222, 32'h902, 1'b1);

      // Asynchronous reset between clock edges
      push(32'h00A0_0513, 32'hA00, 1'b0);
      #1;
      check("ar_pre", count, 4'd2);
      rst = 1'b1;
      #1;
      check("ar_count", count, 4'd0);
      check("ar_valid", instr_valid, 1'b0);
      check("ar_ready", parcel_ready, 1'b1);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("ar_after", count, 4'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
